// File: rtl/adder_tree_pkg.sv
// ============================================================================
// Module      : adder_tree_pkg
// Description : Shared types and default constants for the adder-tree job
//               controller: FSM state encoding and the validity token.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package adder_tree_pkg;

    localparam int LANES    = 64;
    localparam int DW       = 32;
    localparam int TREE_LAT = 6;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic vld;
        logic last;
    } token_t;

endpackage

`default_nettype wire

// File: rtl/adder_tree_job_ctrl_if.sv
// ============================================================================
// Module      : adder_tree_job_ctrl_if
// Description : Job, chunk, tree and result signals of the adder-tree job
//               controller. res_ovf exists only with ADDER_TREE_CTRL_OVF_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface adder_tree_job_ctrl_if #(
    parameter int LANES = adder_tree_pkg::LANES,
    parameter int DW    = adder_tree_pkg::DW,
    parameter int LEN_W = 16,
    parameter int ACC_W = 48
);
    logic                        job_valid;
    logic                        job_ready;
    logic [LEN_W-1:0]            job_len;
    logic                        chunk_valid;
    logic                        chunk_ready;
    logic [0:LANES-1][DW-1:0]    chunk_data;
    logic [0:LANES-1][DW-1:0]    tree_din;
    logic [DW-1:0]               tree_sum;
    logic                        res_valid;
    logic                        res_ready;
    logic [ACC_W-1:0]            res_sum;
    logic                        busy;
`ifdef ADDER_TREE_CTRL_OVF_EN
    logic                        res_ovf;
`endif

    modport slave (
        input  job_valid, job_len, chunk_valid, chunk_data, tree_sum, res_ready,
`ifdef ADDER_TREE_CTRL_OVF_EN
        output res_ovf,
`endif
        output job_ready, chunk_ready, tree_din, res_valid, res_sum, busy
    );

    modport master (
        output job_valid, job_len, chunk_valid, chunk_data, tree_sum, res_ready,
`ifdef ADDER_TREE_CTRL_OVF_EN
        input  res_ovf,
`endif
        input  job_ready, chunk_ready, tree_din, res_valid, res_sum, busy
    );

endinterface

`default_nettype wire

// File: rtl/adder_tree_tok_pipe.sv
// ============================================================================
// Module      : adder_tree_tok_pipe
// Description : DEPTH-stage validity token shift register running alongside
//               the adder tree; the output token is aligned with tree_sum.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_tree_tok_pipe
    import adder_tree_pkg::*;
#(
    parameter int DEPTH = TREE_LAT
) (
    input  logic   clk,
    input  logic   rst_n,
    input  token_t tok_in,
    output token_t tok_out
);

    token_t r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_stage[k] <= '0;
            end
        end else begin
            r_stage[0] <= tok_in;
            for (int k = 1; k < DEPTH; k++) begin
                r_stage[k] <= r_stage[k-1];
            end
        end
    end

    assign tok_out = r_stage[DEPTH-1];

endmodule

`default_nettype wire

// File: rtl/adder_tree_job_ctrl.sv
// ============================================================================
// Module      : adder_tree_job_ctrl
// Description : Feeds a job of N chunks into the adder tree, accumulates the
//               valid tree outputs and presents the job total on a result port.
//               ADDER_TREE_CTRL_OVF_EN adds a saturating accumulator + res_ovf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module adder_tree_job_ctrl #(
    parameter int LANES    = adder_tree_pkg::LANES,
    parameter int DW       = adder_tree_pkg::DW,
    parameter int TREE_LAT = adder_tree_pkg::TREE_LAT,
    parameter int LEN_W    = 16,
    parameter int ACC_W    = 48
) (
    input  logic                  clk,
    input  logic                  rst_n,
    adder_tree_job_ctrl_if.slave  bus
);
    import adder_tree_pkg::*;

    state_t                   r_state;
    logic [LEN_W-1:0]         r_remaining;
    logic [ACC_W-1:0]         r_acc;
    logic                     r_job_ready;
    logic                     r_chunk_ready;
    logic                     r_res_valid;
    logic                     r_busy;

    logic                     w_job_fire;
    logic                     w_chunk_fire;
    logic                     w_last_chunk;
    logic [0:LANES-1][DW-1:0] w_din;
    token_t                   w_tok_in;
    token_t                   w_tok_out;

    assign w_job_fire   = bus.job_valid & r_job_ready;
    assign w_chunk_fire = bus.chunk_valid & r_chunk_ready;
    assign w_last_chunk = (r_remaining == LEN_W'(1));

    // Bubbles present zero to the tree; the token pipe decides what counts.
    assign w_din        = w_chunk_fire ? bus.chunk_data : '0;
    assign bus.tree_din = w_din;
    assign w_tok_in     = '{vld: w_chunk_fire, last: w_chunk_fire & w_last_chunk};

    adder_tree_tok_pipe #(
        .DEPTH   (TREE_LAT)
    ) u_tok_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tok_in  (w_tok_in),
        .tok_out (w_tok_out)
    );

`ifdef ADDER_TREE_CTRL_OVF_EN
    logic             r_ovf;
    logic [ACC_W:0]   w_acc_sum;
    assign w_acc_sum   = {1'b0, r_acc} + (ACC_W+1)'(bus.tree_sum);
    assign bus.res_ovf = r_ovf;
`else
    logic [ACC_W-1:0] w_acc_sum;
    assign w_acc_sum   = r_acc + ACC_W'(bus.tree_sum);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_remaining   <= '0;
            r_acc         <= '0;
            r_job_ready   <= 1'b1;
            r_chunk_ready <= 1'b0;
            r_res_valid   <= 1'b0;
            r_busy        <= 1'b0;
`ifdef ADDER_TREE_CTRL_OVF_EN
            r_ovf         <= 1'b0;
`endif
        end else begin
            if (w_tok_out.vld) begin
`ifdef ADDER_TREE_CTRL_OVF_EN
                if (w_acc_sum[ACC_W]) begin
                    r_acc <= '1;
                    r_ovf <= 1'b1;
                end else begin
                    r_acc <= w_acc_sum[ACC_W-1:0];
                end
`else
                r_acc <= w_acc_sum;
`endif
            end

            unique case (r_state)
                IDLE: begin
                    if (w_job_fire) begin
                        r_remaining <= bus.job_len;
                        r_acc       <= '0;
`ifdef ADDER_TREE_CTRL_OVF_EN
                        r_ovf       <= 1'b0;
`endif
                        r_job_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        if (bus.job_len == '0) begin
                            r_state     <= DONE;
                            r_res_valid <= 1'b1;
                        end else begin
                            r_state       <= FEED;
                            r_chunk_ready <= 1'b1;
                        end
                    end
                end
                FEED: begin
                    if (w_chunk_fire) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (w_last_chunk) begin
                            r_state       <= DRAIN;
                            r_chunk_ready <= 1'b0;
                        end
                    end
                end
                DRAIN: begin
                    // The final partial sum lands in r_acc on this same edge.
                    if (w_tok_out.vld && w_tok_out.last) begin
                        r_state     <= DONE;
                        r_res_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.res_ready) begin
                        r_state     <= IDLE;
                        r_res_valid <= 1'b0;
                        r_job_ready <= 1'b1;
                        r_busy      <= 1'b0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.job_ready   = r_job_ready;
    assign bus.chunk_ready = r_chunk_ready;
    assign bus.res_valid   = r_res_valid;
    assign bus.res_sum     = r_acc;
    assign bus.busy        = r_busy;

endmodule

`default_nettype wire

// File: doc/adder_tree_job_ctrl.md
Name: adder_tree_job_ctrl

Overview:
- Sequencer for the pipelined 64-lane adder tree.
- Accepts a job of N 64-element chunks, streams the chunks into the tree at one per cycle, and tracks chunk validity through the fixed tree latency.
- Accumulates the tree outputs into a wide per-job total, then presents that total on a valid/ready result port.
- Sits between a chunk source (memory reader or DMA) and the downstream consumer. The adder_tree instance sits beside it and is driven by it.

Parameters:
- LANES, 64, elements per chunk (tree width; power of 2).
- DW, 32, element width and tree sum width.
- TREE_LAT, 6, tree latency in cycles (log2(LANES); one registered adder per level).
- LEN_W, 16, width of job_len.
- ACC_W, 48, accumulator and result width (ACC_W >= DW).

Ports:
- clk  in  1  clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- job_valid  in  1  job request.
- job_ready  out  1  controller can accept a job.
- job_len  in  LEN_W  number of chunks in the job; sampled on job handshake.
- chunk_valid  in  1  chunk data valid.
- chunk_ready  out  1  controller accepts a chunk this cycle.
- chunk_data  in  DW x [0:LANES-1]  chunk elements.
- tree_din  out  DW x [0:LANES-1]  to adder_tree din.
- tree_sum  in  DW  from adder_tree sum.
- res_valid  out  1  result valid.
- res_ready  in  1  consumer accepts result.
- res_sum  out  ACC_W  job total.
- busy  out  1  state != IDLE.

Behaviour:
- Reset is asynchronous and active-low. On reset:
  - FSM goes to IDLE.
  - job_ready=1; chunk_ready=0; res_valid=0; res_sum=0; busy=0.
  - Accumulator and remaining-chunk counter cleared; all validity tokens cleared.
- FSM states: IDLE, FEED, DRAIN, DONE.
  - IDLE: job_ready=1. A job_valid&job_ready handshake latches job_len into the remaining counter and clears the accumulator.
    - job_len!=0: go to FEED.
    - job_len==0: go straight to DONE, with res_sum=0 valid the cycle after the handshake.
  - FEED: chunk_ready=1.
    - Each chunk_valid&chunk_ready handshake drives tree_din=chunk_data combinationally, pushes token {vld=1, last=(remaining==1)}, and decrements remaining.
    - On the handshake of the last chunk, go to DRAIN.
  - DRAIN: chunk_ready=0. Wait for the last token to exit the pipe.
  - DONE: res_valid=1; res_sum holds the accumulator. Stay in DONE until res_ready. On res_valid&res_ready, go to IDLE.
- Bubbles:
  - On any cycle with no chunk handshake, tree_din=0 and a token with vld=0 is pushed.
  - The tree has no enable or reset, so the token pipe alone decides what gets accumulated.
- Token pipe: TREE_LAT-deep shift register, advancing every cycle. The token leaving it is aligned with tree_sum.
- Accumulation:
  - When the exiting token has vld=1: acc <= acc + zero_extend(tree_sum).
  - If that token also has last=1: go to DONE on the same edge, so the final sum is visible as res_sum in DONE.
- Latency: last chunk handshake at cycle t gives res_valid at t+TREE_LAT+1.
- Throughput: 1 chunk per cycle with no backpressure. Next job accepted the cycle after result handshake.
- Arithmetic: tree sum wraps modulo 2^DW (tree property). Accumulator is unsigned and wraps modulo 2^ACC_W unless the optional feature is enabled.
- Boundary conditions:
  - job_ready=0 outside IDLE; job_valid is ignored then.
  - chunk_valid outside FEED is ignored (chunk_ready=0).
  - res_ready outside DONE has no effect.
  - job_len = 2^LEN_W-1 must complete without counter wrap.
  - Reset asserted in any state (e.g. mid-DRAIN): immediate return to reset values; in-flight tree data is discarded because the tokens are cleared.

Optional Feature:
- Macro: ADDER_TREE_CTRL_OVF_EN.
- When defined:
  - Adds output port res_ovf (1 bit).
  - A carry out of any accumulate saturates acc to all-ones and sets a sticky ovf flag.
  - res_ovf is valid with res_valid. Flag cleared at job accept and on reset.
- When undefined: no res_ovf port; acc wraps.

Decomposition:
- Package adder_tree_pkg holds:
  - state enum (IDLE, FEED, DRAIN, DONE);
  - token struct {vld, last};
  - default constants LANES, DW, TREE_LAT.
- One sub-module: adder_tree_tok_pipe, the TREE_LAT-deep token shift register with async active-low reset.
- The FSM, counter and accumulator live in the top.

Test Plan:
- job_len=1, all elements=1, no stalls -> res_sum=64, res_valid at handshake+7 cycles.
- job_len=3, element[i]=i, chunk_valid toggling 1/0 -> res_sum=6048 (3*2016); bubbles are not accumulated.
- job_len=0 -> res_valid the cycle after job handshake, res_sum=0, no chunk_ready ever asserted.
- res_ready held low 5 cycles in DONE -> res_valid/res_sum stable, job_ready=0, busy=1; handshake then job_ready=1 next cycle.
- ACC_W=32, job_len=2, all elements=0xFFFFFFFF (tree gives 0xFFFFFFC0 per chunk):
  - with macro: res_sum=0xFFFFFFFF, res_ovf=1;
  - without macro: res_sum=0xFFFFFF80.
- rst_n pulsed low in DRAIN, then a new job_len=1 of all 2 -> clean IDLE after reset, res_sum=128 (stale tokens not summed).
